// File: rtl/key_input_pkg.sv
// Shared types and helpers for the key input conditioner.
// Latency: none (declarations only).
// Backpressure: not applicable.
package key_input_pkg;

   // Per-channel debounce / hold state machine
   typedef enum logic [2:0] {
      IDLE,
      PRESS_DEB,
      HELD,
      LONG_HELD,
      RELEASE_DEB
   } key_state_e;

   // Width of the per-channel tick counters: wide enough to hold the larger
   // of the long-press and repeat periods without wrapping.
   function automatic int cnt_width(input int long_ticks, input int repeat_ticks);
      int m;
      m = (long_ticks > repeat_ticks) ? long_ticks : repeat_ticks;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/key_input_ch.sv
// One key channel: 2-flop synchroniser, tick-based debounce FSM, hold/repeat counters.
// Latency: 2 clk sync + DEB_TICKS ticks + 1 clk register from pin to key_press/level.
// Backpressure: none; pulses are fire-and-forget. KEY_REPEAT_EN enables the repeat counter.
module key_input_ch
   import key_input_pkg::*;
#(
   parameter int DEB_TICKS    = 20,
   parameter int LONG_TICKS   = 1000,
   parameter int REPEAT_TICKS = 200,
   parameter int ACTIVE_LOW   = 0,
   parameter bit LATCH        = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick_i,
   input  logic key_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic long_o,
   output logic repeat_o
);

   localparam int              CW        = cnt_width(LONG_TICKS, REPEAT_TICKS);
   localparam logic            IDLE_LVL  = (ACTIVE_LOW != 0);
   localparam logic [CW-1:0]   DEB_LAST  = CW'(DEB_TICKS - 1);
   localparam logic [CW-1:0]   LONG_LAST = CW'(LONG_TICKS - 1);
   localparam logic [CW-1:0]   ONE       = CW'(1);

   logic          sync1_q;
   logic          sync2_q;
   logic          pressed;
   key_state_e    state_q;
   logic [CW-1:0] deb_q;
   logic [CW-1:0] hold_q;
   logic          was_long_q;
   logic          level_q;
   logic          press_q;
   logic          release_q;
   logic          long_q;
`ifdef KEY_REPEAT_EN
   localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_TICKS - 1);
   logic [CW-1:0] rep_q;
   logic          repeat_q;
`endif

   // Two-flop synchroniser; reset loads the released pin level so no false press
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= IDLE_LVL;
         sync2_q <= IDLE_LVL;
      end else begin
         sync1_q <= key_i;
         sync2_q <= sync1_q;
      end
   end

   assign pressed = sync2_q ^ IDLE_LVL;

   // Debounce/hold FSM with its counters and registered pulse/level outputs.
   // Counters stop at their terminal compare, so none of them can wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         deb_q      <= '0;
         hold_q     <= '0;
         was_long_q <= 1'b0;
         level_q    <= 1'b0;
         press_q    <= 1'b0;
         release_q  <= 1'b0;
         long_q     <= 1'b0;
`ifdef KEY_REPEAT_EN
         rep_q      <= '0;
         repeat_q   <= 1'b0;
`endif
      end else begin
         press_q   <= 1'b0;
         release_q <= 1'b0;
         long_q    <= 1'b0;
`ifdef KEY_REPEAT_EN
         repeat_q  <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               if (pressed) begin
                  state_q <= PRESS_DEB;
                  deb_q   <= '0;
               end
            end
            PRESS_DEB: begin
               if (!pressed) begin
                  state_q <= IDLE;
                  deb_q   <= '0;
               end else if (tick_i) begin
                  if (deb_q == DEB_LAST) begin
                     state_q    <= HELD;
                     deb_q      <= '0;
                     hold_q     <= '0;
                     was_long_q <= 1'b0;
                     press_q    <= 1'b1;
                     level_q    <= 1'b1;
                  end else begin
                     deb_q <= deb_q + ONE;
                  end
               end
            end
            HELD: begin
               if (!pressed) begin
                  state_q    <= RELEASE_DEB;
                  deb_q      <= '0;
                  was_long_q <= 1'b0;
               end else if (tick_i) begin
                  hold_q <= hold_q + ONE;
                  if (hold_q == LONG_LAST) begin
                     state_q <= LONG_HELD;
                     long_q  <= 1'b1;
`ifdef KEY_REPEAT_EN
                     rep_q   <= '0;
`endif
                  end
               end
            end
            LONG_HELD: begin
               if (!pressed) begin
                  state_q    <= RELEASE_DEB;
                  deb_q      <= '0;
                  was_long_q <= 1'b1;
               end
`ifdef KEY_REPEAT_EN
               else if (tick_i) begin
                  if (rep_q == REP_LAST) begin
                     rep_q    <= '0;
                     repeat_q <= 1'b1;
                  end else begin
                     rep_q <= rep_q + ONE;
                  end
               end
`endif
            end
            RELEASE_DEB: begin
               // hold/repeat counters are untouched here, so a glitch only pauses them
               if (pressed) begin
                  state_q <= was_long_q ? LONG_HELD : HELD;
                  deb_q   <= '0;
               end else if (tick_i) begin
                  if (deb_q == DEB_LAST) begin
                     state_q   <= IDLE;
                     deb_q     <= '0;
                     hold_q    <= '0;
                     release_q <= 1'b1;
`ifdef KEY_REPEAT_EN
                     rep_q     <= '0;
`endif
                     if (!LATCH) level_q <= 1'b0;
                  end else begin
                     deb_q <= deb_q + ONE;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               deb_q   <= '0;
            end
         endcase
      end
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;
   assign long_o    = long_q;
`ifdef KEY_REPEAT_EN
   assign repeat_o  = repeat_q;
`else
   assign repeat_o  = 1'b0;
`endif

endmodule

// File: rtl/key_input_bank.sv
// N-channel push-button conditioner: shared tick prescaler feeding per-key debounce channels.
// Latency: 2 clk sync + DEB_TICKS ticks + 1 clk to key_press; all pulses 1 clk wide.
// Backpressure: none. Define KEY_REPEAT_EN to enable auto-repeat on key_repeat.
module key_input_bank
   import key_input_pkg::*;
#(
   parameter int                N_KEYS       = 4,
   parameter int                CLK_FREQ     = 50000000,
   parameter int                TICK_HZ      = 1000,
   parameter int                DEB_TICKS    = 20,
   parameter int                LONG_TICKS   = 1000,
   parameter int                REPEAT_TICKS = 200,
   parameter int                ACTIVE_LOW   = 0,
   parameter logic [N_KEYS-1:0] LATCH_MASK   = N_KEYS'(1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_KEYS-1:0] key_in,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release,
   output logic [N_KEYS-1:0] key_long,
   output logic [N_KEYS-1:0] key_repeat
);

   localparam int            TICK_DIV = CLK_FREQ / TICK_HZ;
   localparam int            PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

   if (N_KEYS < 1) begin : g_chk_nkeys
      $error("key_input_bank: N_KEYS must be >= 1");
   end
   if (TICK_DIV < 1) begin : g_chk_div
      $error("key_input_bank: CLK_FREQ/TICK_HZ must be >= 1");
   end
   if (DEB_TICKS < 1) begin : g_chk_deb
      $error("key_input_bank: DEB_TICKS must be >= 1");
   end
   if (LONG_TICKS <= DEB_TICKS) begin : g_chk_long
      $error("key_input_bank: LONG_TICKS must exceed DEB_TICKS");
   end
   if (REPEAT_TICKS < 1) begin : g_chk_rep
      $error("key_input_bank: REPEAT_TICKS must be >= 1");
   end

   logic [PW-1:0] presc_q;
   logic [PW-1:0] presc_d;
   logic          tick;

   // Prescaler next state: tick on the last count, then wrap to zero
   always_comb begin
      tick    = (presc_q == PRE_LAST);
      presc_d = tick ? '0 : presc_q + PW'(1);
   end

   // Prescaler register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) presc_q <= '0;
      else        presc_q <= presc_d;
   end

   for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
      key_input_ch #(
         .DEB_TICKS   (DEB_TICKS),
         .LONG_TICKS  (LONG_TICKS),
         .REPEAT_TICKS(REPEAT_TICKS),
         .ACTIVE_LOW  (ACTIVE_LOW),
         .LATCH       (LATCH_MASK[g])
      ) u_ch (
         .clk      (clk),
         .rst_n    (rst_n),
         .tick_i   (tick),
         .key_i    (key_in[g]),
         .level_o  (key_level[g]),
         .press_o  (key_press[g]),
         .release_o(key_release[g]),
         .long_o   (key_long[g]),
         .repeat_o (key_repeat[g])
      );
   end

endmodule
